// File: rtl/bs_sched.sv
// Bitstream scheduler: walks header, code and trailer sources in order, forwards
// each accepted symbol to the concatenator, then pads the frame to a word boundary.
module bs_sched #(
    parameter int DATA_WD = 32,
    parameter int NUMB_WD = 5,
    parameter int CNT_WD  = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,

    input  logic               hdr_val_i,
    input  logic [DATA_WD-1:0] hdr_dat_i,
    input  logic [NUMB_WD-1:0] hdr_numb_i,
    input  logic               hdr_lst_i,
    output logic               hdr_rdy_o,

    input  logic               cod_val_i,
    input  logic [DATA_WD-1:0] cod_dat_i,
    input  logic [NUMB_WD-1:0] cod_numb_i,
    input  logic               cod_lst_i,
    output logic               cod_rdy_o,

    input  logic               trl_val_i,
    input  logic [DATA_WD-1:0] trl_dat_i,
    input  logic [NUMB_WD-1:0] trl_numb_i,
    input  logic               trl_lst_i,
    output logic               trl_rdy_o,

    output logic               cat_val_o,
    output logic [DATA_WD-1:0] cat_dat_o,
    output logic [NUMB_WD-1:0] cat_numb_o,

    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_WD-1:0]  bits_o
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        COD,
        TRL,
        PAD,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_nxt;

    logic [NUMB_WD-1:0] r_ptr;

    logic               w_sel_val;
    logic [DATA_WD-1:0] w_sel_dat;
    logic [NUMB_WD-1:0] w_sel_numb;
    logic               w_sel_lst;
    logic               w_xfer;
    logic               w_pad_wr;
    logic               w_wr;
    logic [NUMB_WD-1:0] w_wr_numb;
    logic [DATA_WD-1:0] w_mask;
    logic [CNT_WD-1:0]  w_add;

    assign hdr_rdy_o = (r_state == HDR);
    assign cod_rdy_o = (r_state == COD);
    assign trl_rdy_o = (r_state == TRL);
    assign busy_o    = (r_state != IDLE);
    assign done_o    = (r_state == DONE);

    // Next state, source selection and pad decision for the current phase
    always_comb begin
        w_nxt      = r_state;
        w_sel_val  = 1'b0;
        w_sel_dat  = '0;
        w_sel_numb = '0;
        w_sel_lst  = 1'b0;
        w_pad_wr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_nxt = HDR;
            end
            HDR: begin
                w_sel_val  = hdr_val_i;
                w_sel_dat  = hdr_dat_i;
                w_sel_numb = hdr_numb_i;
                w_sel_lst  = hdr_lst_i;
                if (hdr_val_i && hdr_lst_i) w_nxt = COD;
            end
            COD: begin
                w_sel_val  = cod_val_i;
                w_sel_dat  = cod_dat_i;
                w_sel_numb = cod_numb_i;
                w_sel_lst  = cod_lst_i;
                if (cod_val_i && cod_lst_i) w_nxt = TRL;
            end
            TRL: begin
                w_sel_val  = trl_val_i;
                w_sel_dat  = trl_dat_i;
                w_sel_numb = trl_numb_i;
                w_sel_lst  = trl_lst_i;
                if (trl_val_i && trl_lst_i) w_nxt = PAD;
            end
            PAD: begin
                w_pad_wr = (r_ptr != '0);
                w_nxt    = DONE;
            end
            DONE: begin
                w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Write request: symbol transfer or pad; pad count 31-ptr is simply ~ptr
    always_comb begin
        w_xfer    = w_sel_val;
        w_wr      = w_xfer | w_pad_wr;
        w_wr_numb = w_pad_wr ? ~r_ptr : w_sel_numb;
        w_add     = CNT_WD'(w_wr_numb) + CNT_WD'(1);
    end

    // Keep only the numb+1 least significant data bits
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < DATA_WD; i++) begin
            w_mask[i] = (i <= 32'(w_sel_numb));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    // Word pointer mirroring the concatenator, wraps naturally at 2^NUMB_WD
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_pad_wr) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= r_ptr + w_sel_numb + NUMB_WD'(1);
        end
    end

    // Registered concatenator write port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cat_val_o  <= 1'b0;
            cat_dat_o  <= '0;
            cat_numb_o <= '0;
        end else begin
            cat_val_o  <= w_wr;
            cat_dat_o  <= w_xfer ? (w_sel_dat & w_mask) : '0;
            cat_numb_o <= w_wr ? w_wr_numb : '0;
        end
    end

    // Frame bit counter: cleared by an accepted start, held after the frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bits_o <= '0;
        end else if (r_state == IDLE && start_i) begin
            bits_o <= '0;
        end else if (w_wr) begin
            bits_o <= bits_o + w_add;
        end
    end

endmodule

// File: tb/tb_bs_sched.sv
// Self-checking bench for bs_sched: table-driven frames, hand-written corner
// sequences and randomized frames checked against a per-frame arithmetic model.
module tb_bs_sched;

    localparam int DW = 32;
    localparam int NW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic          hdr_val_i = 1'b0, cod_val_i = 1'b0, trl_val_i = 1'b0;
    logic [DW-1:0] hdr_dat_i = '0, cod_dat_i = '0, trl_dat_i = '0;
    logic [NW-1:0] hdr_numb_i = '0, cod_numb_i = '0, trl_numb_i = '0;
    logic          hdr_lst_i = 1'b0, cod_lst_i = 1'b0, trl_lst_i = 1'b0;
    logic          hdr_rdy_o, cod_rdy_o, trl_rdy_o;
    logic          cat_val_o;
    logic [DW-1:0] cat_dat_o;
    logic [NW-1:0] cat_numb_o;
    logic          busy_o, done_o;
    logic [CW-1:0] bits_o;

    always #5 clk = ~clk;

    bs_sched #(.DATA_WD(DW), .NUMB_WD(NW), .CNT_WD(CW)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i),
        .hdr_val_i(hdr_val_i), .hdr_dat_i(hdr_dat_i), .hdr_numb_i(hdr_numb_i),
        .hdr_lst_i(hdr_lst_i), .hdr_rdy_o(hdr_rdy_o),
        .cod_val_i(cod_val_i), .cod_dat_i(cod_dat_i), .cod_numb_i(cod_numb_i),
        .cod_lst_i(cod_lst_i), .cod_rdy_o(cod_rdy_o),
        .trl_val_i(trl_val_i), .trl_dat_i(trl_dat_i), .trl_numb_i(trl_numb_i),
        .trl_lst_i(trl_lst_i), .trl_rdy_o(trl_rdy_o),
        .cat_val_o(cat_val_o), .cat_dat_o(cat_dat_o), .cat_numb_o(cat_numb_o),
        .busy_o(busy_o), .done_o(done_o), .bits_o(bits_o)
    );

    typedef struct {
        int            ph;     // 0 header, 1 code, 2 trailer
        logic [DW-1:0] dat;
        logic [NW-1:0] numb;
        logic          lst;
    } sym_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic [NW-1:0] numb;
    } wr_t;

    typedef struct {
        logic [NW-1:0] hn, cn, tn;
        logic [DW-1:0] dat;
        int            exp_n;
        int            exp_pad;   // -1: no pad write expected
        logic [CW-1:0] exp_bits;
        logic [DW-1:0] exp_w0;
        bit            pre031;
        bit            st_cod;
    } vec_t;

    int   nvec = 0;
    int   nmis = 0;
    sym_t fq[$];
    wr_t  got[$];
    int   ndone = 0;
    int   rdy_err = 0;
    logic [CW-1:0] done_bits = '0;

    // Capture every write, done pulse and ready overlap away from the active edge
    always @(negedge clk) begin
        if (cat_val_o) got.push_back('{cat_dat_o, cat_numb_o});
        if (done_o) begin
            ndone++;
            done_bits = bits_o;
        end
        if ((32'(hdr_rdy_o) + 32'(cod_rdy_o) + 32'(trl_rdy_o)) > 1) rdy_err++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy_of(input int p);
        case (p)
            0:       return hdr_rdy_o;
            1:       return cod_rdy_o;
            default: return trl_rdy_o;
        endcase
    endfunction

    task automatic idle_inputs(input bit junk);
        hdr_val_i = junk & 1'($urandom); hdr_dat_i = $urandom; hdr_numb_i = NW'($urandom); hdr_lst_i = 1'($urandom);
        cod_val_i = junk & 1'($urandom); cod_dat_i = $urandom; cod_numb_i = NW'($urandom); cod_lst_i = 1'($urandom);
        trl_val_i = junk & 1'($urandom); trl_dat_i = $urandom; trl_numb_i = NW'($urandom); trl_lst_i = 1'($urandom);
    endtask

    task automatic set_inputs(input sym_t s, input bit junk, input bit ownv);
        idle_inputs(junk);
        case (s.ph)
            0: begin hdr_val_i = ownv; hdr_dat_i = s.dat; hdr_numb_i = s.numb; hdr_lst_i = s.lst; end
            1: begin cod_val_i = ownv; cod_dat_i = s.dat; cod_numb_i = s.numb; cod_lst_i = s.lst; end
            default: begin trl_val_i = ownv; trl_dat_i = s.dat; trl_numb_i = s.numb; trl_lst_i = s.lst; end
        endcase
    endtask

    // Present one symbol and hold it until its phase is ready; it transfers on the next edge
    task automatic send(input sym_t s, input bit junk, input bit st);
        int t = 0;
        @(negedge clk);
        set_inputs(s, junk, 1'b1);
        start_i = st;
        while (!rdy_of(s.ph) && t < 40) begin
            @(negedge clk);
            start_i = 1'b0;
            t++;
        end
        chk("rdy_phase", 64'(rdy_of(s.ph)), 64'd1);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_cat_val"}, 64'(cat_val_o), 64'd0);
        chk({tag, "_cat_dat"}, 64'(cat_dat_o), 64'd0);
        chk({tag, "_cat_numb"}, 64'(cat_numb_o), 64'd0);
        chk({tag, "_rdy"}, 64'({hdr_rdy_o, cod_rdy_o, trl_rdy_o}), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_bits"}, 64'(bits_o), 64'd0);
    endtask

    // Run the frame held in fq and compare against the model built from fq
    task automatic run_frame(input bit junk, input bit st_cod, input bit pre031, input int gap_pct,
                             output int n_wr, output logic [NW-1:0] last_numb,
                             output logic [DW-1:0] w0, output logic [CW-1:0] fbits);
        int          base, d0, t, total, rem;
        wr_t         exp_q[$];
        bit          cod_first;
        logic [63:0] m;
        base  = got.size();
        d0    = ndone;
        total = 0;
        foreach (fq[i]) begin
            m = (64'd1 << (int'(fq[i].numb) + 1)) - 64'd1;
            exp_q.push_back('{fq[i].dat & m[DW-1:0], fq[i].numb});
            total += int'(fq[i].numb) + 1;
        end
        rem = total % DW;
        if (rem != 0) begin
            exp_q.push_back('{32'd0, NW'(31 - rem)});
            total += DW - rem;
        end

        @(negedge clk);
        idle_inputs(junk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        idle_inputs(1'b0);
        chk("busy_after_start", 64'(busy_o), 64'd1);
        chk("bits_cleared", 64'(bits_o), 64'd0);

        if (pre031) begin
            repeat (4) begin
                cod_val_i = 1'b1; cod_lst_i = 1'b1; cod_dat_i = $urandom; cod_numb_i = NW'($urandom);
                @(negedge clk);
                chk("cod_rdy_in_hdr", 64'(cod_rdy_o), 64'd0);
                chk("hdr_rdy_in_hdr", 64'(hdr_rdy_o), 64'd1);
                chk("no_write_in_hdr", 64'(got.size() - base), 64'd0);
            end
            cod_val_i = 1'b0;
        end

        cod_first = 1'b1;
        foreach (fq[i]) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                @(negedge clk);
                set_inputs(fq[i], junk, 1'b0);
            end
            send(fq[i], junk, st_cod && fq[i].ph == 1 && cod_first);
            if (fq[i].ph == 1) cod_first = 1'b0;
        end
        @(negedge clk);
        idle_inputs(junk);

        t = 0;
        while (ndone == d0 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("done_seen", 64'(ndone != d0), 64'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        idle_inputs(1'b0);
        chk("done_once", 64'(ndone - d0), 64'd1);
        chk("done_bits", 64'(done_bits), 64'(total));
        chk("bits_hold", 64'(bits_o), 64'(total));
        chk("busy_idle", 64'(busy_o), 64'd0);
        chk("done_low", 64'(done_o), 64'd0);

        n_wr = got.size() - base;
        chk("n_writes", 64'(n_wr), 64'(exp_q.size()));
        for (int i = 0; i < n_wr && i < exp_q.size(); i++) begin
            chk("wr_dat", 64'(got[base+i].dat), 64'(exp_q[i].dat));
            chk("wr_numb", 64'(got[base+i].numb), 64'(exp_q[i].numb));
        end
        w0        = (n_wr > 0) ? got[base].dat : 'x;
        last_numb = (n_wr > 0) ? got[base+n_wr-1].numb : 'x;
        fbits     = bits_o;
    endtask

    vec_t tbl[5];

    initial begin
        int            n_wr;
        logic [NW-1:0] ln;
        logic [DW-1:0] w0;
        logic [CW-1:0] fb;
        int            d0;

        tbl[0] = '{5'd2,  5'd7,  5'd4,  32'hFFFFFFFF, 4, 15, 32'd32, 32'h00000007, 1'b1, 1'b0};
        tbl[1] = '{5'd31, 5'd31, 5'd31, 32'hA5A5A5A5, 3, -1, 32'd96, 32'hA5A5A5A5, 1'b0, 1'b1};
        tbl[2] = '{5'd3,  5'd0,  5'd0,  32'hFFFFFFFF, 4, 25, 32'd32, 32'h0000000F, 1'b0, 1'b0};
        tbl[3] = '{5'd0,  5'd0,  5'd0,  32'h00000002, 4, 28, 32'd32, 32'h00000000, 1'b0, 1'b0};
        tbl[4] = '{5'd15, 5'd15, 5'd31, 32'h12345678, 3, -1, 32'd64, 32'h00005678, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        #1;
        reset_chk("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Table-driven single-symbol-per-phase frames
        for (int v = 0; v < 5; v++) begin
            fq.delete();
            fq.push_back('{0, tbl[v].dat, tbl[v].hn, 1'b1});
            fq.push_back('{1, tbl[v].dat, tbl[v].cn, 1'b1});
            fq.push_back('{2, tbl[v].dat, tbl[v].tn, 1'b1});
            run_frame(1'b0, tbl[v].st_cod, tbl[v].pre031, 0, n_wr, ln, w0, fb);
            chk("tbl_n_writes", 64'(n_wr), 64'(tbl[v].exp_n));
            chk("tbl_bits", 64'(fb), 64'(tbl[v].exp_bits));
            chk("tbl_w0", 64'(w0), 64'(tbl[v].exp_w0));
            if (tbl[v].exp_pad >= 0) chk("tbl_pad_numb", 64'(ln), 64'(tbl[v].exp_pad));
            else                     chk("tbl_last_numb", 64'(ln), 64'(tbl[v].tn));
        end

        // Reset in the middle of the code phase, then a minimal clean frame
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        send('{0, 32'h5, 5'd3, 1'b1}, 1'b0, 1'b0);
        send('{1, 32'hAB, 5'd7, 1'b0}, 1'b0, 1'b0);
        send('{1, 32'hCD, 5'd7, 1'b0}, 1'b0, 1'b0);
        @(negedge clk);
        d0   = ndone;
        rstn = 1'b0;
        idle_inputs(1'b0);
        #1;
        reset_chk("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 64'(ndone - d0), 64'd0);
        chk("midrst_no_write", 64'(cat_val_o), 64'd0);
        rstn = 1'b1;
        fq.delete();
        fq.push_back('{0, 32'h1, 5'd0, 1'b1});
        fq.push_back('{1, 32'h0, 5'd0, 1'b1});
        fq.push_back('{2, 32'h1, 5'd0, 1'b1});
        run_frame(1'b0, 1'b0, 1'b0, 0, n_wr, ln, w0, fb);
        chk("rst_frame_pad", 64'(ln), 64'd28);
        chk("rst_frame_bits", 64'(fb), 64'd32);

        // Randomized frames: several symbols per phase, gaps and junk on idle sources
        for (int f = 0; f < 40; f++) begin
            fq.delete();
            for (int p = 0; p < 3; p++) begin
                int ns;
                ns = $urandom_range(1, 4);
                for (int k = 0; k < ns; k++) begin
                    logic [NW-1:0] nb;
                    nb = ($urandom_range(3) == 0) ? NW'(31) : NW'($urandom);
                    fq.push_back('{p, DW'($urandom), nb, (k == ns - 1)});
                end
            end
            run_frame(1'($urandom), 1'($urandom), 1'b0, ($urandom_range(1) == 1) ? 30 : 0,
                      n_wr, ln, w0, fb);
        end

        chk("rdy_onehot", 64'(rdy_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/bs_sched.md
BS_SCHED -- requirements
Module: bs_sched

Interface
REQ-001 Parameter DATA_WD, default 32, width of the data field and of the concatenator word.
REQ-002 Parameter NUMB_WD, default 5, width of bit-count fields; count encoding is value+1 valid bits (0 means 1 bit, 31 means 32 bits).
REQ-003 Parameter CNT_WD, default 32, width of the total-bit counter.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  single-cycle pulse that begins one frame.
REQ-007 hdr_val_i / hdr_dat_i / hdr_numb_i / hdr_lst_i  in  1/DATA_WD/NUMB_WD/1  header source: valid, LSB-aligned bits, count, last symbol of phase.
REQ-008 hdr_rdy_o  out  1  header source ready.
REQ-009 cod_* and trl_*  same ports and widths as hdr_*  code source and trailer source.
REQ-010 cat_val_o / cat_dat_o / cat_numb_o  out  1/DATA_WD/NUMB_WD  registered write to the bitstream concatenator.
REQ-011 busy_o  out  1  high from the cycle after accepted start_i until DONE exits.
REQ-012 done_o  out  1  one-cycle pulse at frame end.
REQ-013 bits_o  out  CNT_WD  total bits written this frame, including pad.

Function
REQ-014 The FSM SHALL have states IDLE, HDR, COD, TRL, PAD, DONE.
REQ-015 IDLE->HDR on start_i; start_i in any other state SHALL be ignored.
REQ-016 In HDR/COD/TRL only the matching rdy SHALL be 1, combinationally from state; all other rdy 0.
REQ-017 Transfer = val & rdy; each transfer SHALL produce cat_val_o=1 next cycle with cat_dat_o = dat masked to numb+1 LSBs and cat_numb_o = numb.
REQ-018 A transfer with lst=1 SHALL advance HDR->COD, COD->TRL, TRL->PAD in the same edge; each phase requires >=1 transfer.
REQ-019 Internal ptr (NUMB_WD bits) SHALL track bits mod DATA_WD: ptr <= (ptr + numb + 1) mod 32 per write, identical to the concatenator's pointer.
REQ-020 PAD, one cycle: if ptr!=0, issue one write of zeros with cat_numb_o = 31 - ptr (fills to word boundary), ptr->0; if ptr==0, no write. Then ->DONE.
REQ-021 DONE SHALL assert done_o for exactly one cycle, then ->IDLE; bits_o holds its value until the next accepted start_i clears it to 0.
REQ-022 bits_o SHALL add numb+1 per write (pad included), wrapping modulo 2^CNT_WD.
REQ-023 cat_val_o SHALL be 0 in every cycle without a transfer or pad write; no back-pressure from the concatenator (always accepts).
REQ-024 Max throughput one symbol per cycle, including the lst transfer followed by next phase's first transfer on the next cycle.
REQ-025 val without rdy (wrong phase, IDLE, PAD, DONE) SHALL be ignored and never written.
REQ-026 Values of dat above bit numb SHALL not appear on cat_dat_o.

Reset
REQ-027 On rstn low, immediately: state IDLE, ptr 0, all rdy 0, cat_val_o 0, cat_dat_o 0, cat_numb_o 0, busy_o 0, done_o 0, bits_o 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no pad write and no done_o; next start_i begins a clean frame.

Verification
REQ-029 Header 3 bits (numb 2, lst), code 8 bits (numb 7, lst), trailer 5 bits (numb 4, lst) -> three writes, then pad write cat_numb_o=15 zeros, done_o pulse, bits_o=32.
REQ-030 Header numb 31 lst, code numb 31 lst, trailer numb 31 lst -> ptr 0 at PAD, no pad write, bits_o=96.
REQ-031 cod_val_i held high during HDR with hdr_val_i low -> cod_rdy_o 0, no write; first write appears only after header lst.
REQ-032 hdr_dat_i=32'hFFFFFFFF numb 3 -> cat_dat_o=32'h0000000F, cat_numb_o=3.
REQ-033 start_i pulsed during COD -> ignored; frame completes normally with single done_o.
REQ-034 rstn low after 2 code writes, release, start_i, minimal frame of 1+1+1 bits -> pad numb 28, bits_o=32.
